// File: rtl/mcmac_iter_pkg.sv
// Shared types and helpers for the iterative multiply-accumulate unit.
// Extension helper works on a 64-bit carrier, so operand and accumulator widths stay <= 64.
package mcmac_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int EXT_W = 64;

    function automatic int cnt_width(input int ii);
        return (ii > 1) ? $clog2(ii) : 1;
    endfunction

    // Keep the low w bits of v and fill the rest with bit w-1 (sgn=1) or zeros (sgn=0).
    function automatic logic [EXT_W-1:0] ext_fn(input logic [EXT_W-1:0] v, input int w, input logic sgn);
        logic [EXT_W-1:0] tmp;
        logic [EXT_W-1:0] res;
        tmp = v << (EXT_W - w);
        if (sgn) begin
            res = $unsigned($signed(tmp) >>> (EXT_W - w));
        end else begin
            res = tmp >> (EXT_W - w);
        end
        return res;
    endfunction

endpackage

// File: rtl/mcmac_iter_if.sv
// Operand/result bundle between the operand sequencer and the MAC unit.
interface mcmac_iter_if #(
    parameter int N    = 8,
    parameter int M    = 8,
    parameter int ACCW = 32
);
    logic              start;
    logic              sign;
    logic              acc_en;
    logic              acc_clr;
    logic [N-1:0]      aa;
    logic [M-1:0]      bb;
    logic              ready;
    logic              done;
    logic [N+M-1:0]    out;
    logic [ACCW-1:0]   acc;
    logic              overrun;
    logic              acc_ovf;

    modport master (
        output start, sign, acc_en, acc_clr, aa, bb,
        input  ready, done, out, acc, overrun, acc_ovf
    );

    modport slave (
        input  start, sign, acc_en, acc_clr, aa, bb,
        output ready, done, out, acc, overrun, acc_ovf
    );
endinterface

// File: rtl/mcmac_iter_pp.sv
// Combinational N x CH partial-product generator; each operand is sign- or zero-extended
// to N+CH bits, which always holds the exact product.
module mcmac_pp
    import mcmac_pkg::*;
#(
    parameter int N  = 8,
    parameter int CH = 2
) (
    input  logic [N-1:0]    a,
    input  logic [CH-1:0]   b,
    input  logic            a_signed,
    input  logic            b_signed,
    output logic [N+CH-1:0] p
);
    localparam int W = N + CH;

    logic [W-1:0] a_ext_s;
    logic [W-1:0] b_ext_s;

    // Extend both operands to the product width and multiply modulo 2^W.
    always_comb begin
        a_ext_s = W'(ext_fn(EXT_W'(a), N, a_signed));
        b_ext_s = W'(ext_fn(EXT_W'(b), CH, b_signed));
        p       = a_ext_s * b_ext_s;
    end
endmodule

// File: rtl/mcmac_iter.sv
// Iterative multiply-accumulate: consumes bb in II chunks of M/II bits, LSB first,
// then registers the product and optionally folds it into a running accumulator.
module mcmac_iter
    import mcmac_pkg::*;
#(
    parameter int N    = 8,
    parameter int M    = 8,
    parameter int II   = 4,
    parameter int ACCW = 32
) (
    input  logic       clk,
    input  logic       rst,
    mcmac_iter_if.slave bus
);
    localparam int CH  = M / II;
    localparam int P   = N + M;
    localparam int CW  = cnt_width(II);
    localparam int SHW = cnt_width(M) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(II - 1);

    generate
        if ((II < 1) || (II > M) || ((M % II) != 0)) begin : g_bad_ii
            $error("mcmac_iter: II must divide M and lie in 1..M");
        end
        if ((ACCW < P) || (ACCW > EXT_W)) begin : g_bad_accw
            $error("mcmac_iter: ACCW must be in N+M..64");
        end
    endgenerate

    state_e          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic [SHW-1:0]  sh_r;
    logic [N-1:0]    aa_r;
    logic [M-1:0]    bb_r;
    logic            sign_r, acc_en_r, acc_clr_r;
    logic [P-1:0]    psum_r, out_r;
    logic [ACCW-1:0] acc_r;
    logic            done_r, overrun_r, acc_ovf_r;

    logic [CH-1:0]   chunk_s;
    logic            last_s, chunk_signed_s, accept_s, finish_s;
    logic [N+CH-1:0] pp_s;
    logic [P-1:0]    pp_ext_s, term_s, sum_s;
    logic [ACCW-1:0] base_s, addend_s, acc_new_s;
    logic            carry_s, sovf_s, ovf_hit_s;

    // bb_r is shifted down each RUN cycle, so the current chunk is always its LSBs;
    // only the top chunk carries the sign of bb.
    assign chunk_s        = bb_r[CH-1:0];
    assign last_s         = (cnt_r == LAST_CNT);
    assign chunk_signed_s = sign_r & last_s;
    assign accept_s       = bus.start & (state_r == S_IDLE);
    assign finish_s       = (state_r == S_RUN) & last_s;

    mcmac_pp #(.N(N), .CH(CH)) u_pp (
        .a        (aa_r),
        .b        (chunk_s),
        .a_signed (sign_r),
        .b_signed (chunk_signed_s),
        .p        (pp_s)
    );

    // Partial-sum step and accumulator update with carry / signed-overflow detection.
    always_comb begin
        pp_ext_s  = P'(ext_fn(EXT_W'(pp_s), N + CH, sign_r));
        term_s    = pp_ext_s << sh_r;
        sum_s     = psum_r + term_s;
        base_s    = acc_clr_r ? {ACCW{1'b0}} : acc_r;
        addend_s  = ACCW'(ext_fn(EXT_W'(sum_s), P, sign_r));
        {carry_s, acc_new_s} = {1'b0, base_s} + {1'b0, addend_s};
        sovf_s    = (base_s[ACCW-1] == addend_s[ACCW-1]) && (acc_new_s[ACCW-1] != base_s[ACCW-1]);
        ovf_hit_s = sign_r ? sovf_s : carry_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) state_s = S_RUN;
                else           state_s = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_s = S_IDLE;
                else        state_s = S_RUN;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Operand capture and chunk iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            sh_r      <= {SHW{1'b0}};
            aa_r      <= {N{1'b0}};
            bb_r      <= {M{1'b0}};
            sign_r    <= 1'b0;
            acc_en_r  <= 1'b0;
            acc_clr_r <= 1'b0;
            psum_r    <= {P{1'b0}};
        end else if (accept_s) begin
            cnt_r     <= {CW{1'b0}};
            sh_r      <= {SHW{1'b0}};
            aa_r      <= bus.aa;
            bb_r      <= bus.bb;
            sign_r    <= bus.sign;
            acc_en_r  <= bus.acc_en;
            acc_clr_r <= bus.acc_clr;
            psum_r    <= {P{1'b0}};
        end else if (state_r == S_RUN) begin
            cnt_r     <= cnt_r + CW'(1);
            sh_r      <= sh_r + SHW'(CH);
            bb_r      <= bb_r >> CH;
            psum_r    <= sum_s;
        end
    end

    // Result, accumulator and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r    <= 1'b0;
            out_r     <= {P{1'b0}};
            acc_r     <= {ACCW{1'b0}};
            overrun_r <= 1'b0;
            acc_ovf_r <= 1'b0;
        end else begin
            done_r <= finish_s;
            if (finish_s) begin
                out_r <= sum_s;
                if (acc_en_r) begin
                    acc_r <= acc_new_s;
                    if (ovf_hit_s) acc_ovf_r <= 1'b1;
                end
            end
            if (bus.start && (state_r != S_IDLE)) overrun_r <= 1'b1;
        end
    end

    assign bus.ready   = (state_r == S_IDLE);
    assign bus.done    = done_r;
    assign bus.out     = out_r;
    assign bus.acc     = acc_r;
    assign bus.overrun = overrun_r;
    assign bus.acc_ovf = acc_ovf_r;
endmodule

// File: tb/tb_mcmac_iter.sv
// Directed and random bench for mcmac_iter with a scoreboard of expected results.
module tb_mcmac_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mcmac_iter_if #(.N(8),  .M(8),  .ACCW(32)) b0 ();
    mcmac_iter_if #(.N(8),  .M(8),  .ACCW(16)) b1 ();
    mcmac_iter_if #(.N(16), .M(12), .ACCW(32)) b2 ();

    mcmac_iter #(.N(8),  .M(8),  .II(4), .ACCW(32)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mcmac_iter #(.N(8),  .M(8),  .II(2), .ACCW(16)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mcmac_iter #(.N(16), .M(12), .II(3), .ACCW(32)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic [31:0] out;
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb2[$];
    logic [31:0] m_acc0, m_acc2;
    logic        m_ovf0, m_ovf2;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prod_model(input int nw, input int mw, input logic sgn,
                                               input logic [63:0] a, input logic [63:0] b);
        longint      av, bv, p;
        logic [63:0] r;
        av = longint'(a);
        bv = longint'(b);
        if (sgn && a[nw-1]) av = av - (longint'(1) << nw);
        if (sgn && b[mw-1]) bv = bv - (longint'(1) << mw);
        p = av * bv;
        r = p;
        return r & ((64'd1 << (nw + mw)) - 64'd1);
    endfunction

    // Value-level accumulator model: overflow is "true sum leaves the representable range".
    function automatic void acc_model(input int pw, input int accw, input logic sgn, input logic en,
                                      input logic clr, input logic [63:0] outv,
                                      inout logic [31:0] acc, inout logic ovf);
        longint      base, addv, s;
        logic [63:0] sv;
        base = clr ? 64'sd0 : longint'({32'd0, acc});
        addv = longint'(outv);
        if (sgn) begin
            if (!clr && acc[accw-1]) base = base - (longint'(1) << accw);
            if (outv[pw-1])          addv = addv - (longint'(1) << pw);
        end
        s  = base + addv;
        sv = s;
        if (en) begin
            acc = 32'(sv & ((64'd1 << accw) - 64'd1));
            if (sgn) begin
                if (s > ((longint'(1) << (accw - 1)) - 1) || s < -(longint'(1) << (accw - 1))) ovf = 1'b1;
            end else begin
                if (s >= (longint'(1) << accw)) ovf = 1'b1;
            end
        end
    endfunction

    task automatic issue0(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          input logic en, input logic clr);
        exp_t e;
        b0.sign = sgn; b0.aa = a; b0.bb = b; b0.acc_en = en; b0.acc_clr = clr; b0.start = 1'b1;
        e.out = 32'(prod_model(8, 8, sgn, 64'(a), 64'(b)));
        acc_model(16, 32, sgn, en, clr, 64'(e.out), m_acc0, m_ovf0);
        e.acc = m_acc0;
        e.ovf = m_ovf0;
        sb0.push_back(e);
        @(posedge clk); #1;
        b0.start = 1'b0;
    endtask

    task automatic wait0(input int lat);
        int   n = 0;
        exp_t e;
        while (b0.done !== 1'b1 && n < 20) begin
            chk("ready_low_in_run", 64'(b0.ready), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency0", 64'(n), 64'(lat));
        chk("done0", 64'(b0.done), 64'd1);
        chk("ready_at_done0", 64'(b0.ready), 64'd1);
        chk("sb0_nonempty", 64'(sb0.size() > 0), 64'd1);
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("out0", 64'(b0.out), 64'(e.out));
            chk("acc0", 64'(b0.acc), 64'(e.acc));
            chk("ovf0", 64'(b0.acc_ovf), 64'(e.ovf));
        end
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic clr);
        int n = 0;
        b1.sign = 1'b0; b1.aa = a; b1.bb = b; b1.acc_en = 1'b1; b1.acc_clr = clr; b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        while (b1.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency1", 64'(n), 64'd2);
        chk("out1", 64'(b1.out), prod_model(8, 8, 1'b0, 64'(a), 64'(b)));
    endtask

    task automatic run2(input logic sgn, input logic [15:0] a, input logic [11:0] b,
                        input logic en, input logic clr);
        int   n = 0;
        exp_t e;
        b2.sign = sgn; b2.aa = a; b2.bb = b; b2.acc_en = en; b2.acc_clr = clr; b2.start = 1'b1;
        e.out = 32'(prod_model(16, 12, sgn, 64'(a), 64'(b)));
        acc_model(28, 32, sgn, en, clr, 64'(e.out), m_acc2, m_ovf2);
        e.acc = m_acc2;
        e.ovf = m_ovf2;
        sb2.push_back(e);
        @(posedge clk); #1;
        b2.start = 1'b0;
        while (b2.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency2", 64'(n), 64'd3);
        e = sb2.pop_front();
        chk("out2", 64'(b2.out), 64'(e.out));
        chk("acc2", 64'(b2.acc), 64'(e.acc));
        chk("ovf2", 64'(b2.acc_ovf), 64'(e.ovf));
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        b0.start = 1'b0; b0.sign = 1'b0; b0.acc_en = 1'b0; b0.acc_clr = 1'b0; b0.aa = 8'd0;  b0.bb = 8'd0;
        b1.start = 1'b0; b1.sign = 1'b0; b1.acc_en = 1'b0; b1.acc_clr = 1'b0; b1.aa = 8'd0;  b1.bb = 8'd0;
        b2.start = 1'b0; b2.sign = 1'b0; b2.acc_en = 1'b0; b2.acc_clr = 1'b0; b2.aa = 16'd0; b2.bb = 12'd0;
        m_acc0 = 32'd0; m_ovf0 = 1'b0; m_acc2 = 32'd0; m_ovf2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(b0.ready), 64'd1);
        chk("rst_done", 64'(b0.done), 64'd0);
        chk("rst_out", 64'(b0.out), 64'd0);
        chk("rst_acc", 64'(b0.acc), 64'd0);
        chk("rst_overrun", 64'(b0.overrun), 64'd0);
        chk("rst_acc_ovf", 64'(b0.acc_ovf), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned max x max, then check the done pulse drops and out holds.
        issue0(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        wait0(4);
        chk("u_ff_ff", 64'(b0.out), 64'hFE01);
        @(posedge clk); #1;
        chk("done_pulse", 64'(b0.done), 64'd0);
        chk("out_hold", 64'(b0.out), 64'hFE01);

        // Signed corner cases.
        issue0(1'b1, 8'h80, 8'hFF, 1'b0, 1'b0);
        wait0(4);
        chk("s_80_ff", 64'(b0.out), 64'h0080);
        issue0(1'b1, 8'h7F, 8'h80, 1'b0, 1'b0);
        wait0(4);
        chk("s_7f_80", 64'(b0.out), 64'hC080);

        // Back-to-back accumulate: start issued in each done cycle.
        issue0(1'b0, 8'd100, 8'd100, 1'b1, 1'b1);
        wait0(4);
        issue0(1'b0, 8'd100, 8'd100, 1'b1, 1'b0);
        wait0(4);
        issue0(1'b0, 8'd100, 8'd100, 1'b1, 1'b0);
        wait0(4);
        chk("acc_30000", 64'(b0.acc), 64'd30000);

        // Start while busy is ignored and flagged.
        @(posedge clk); #1;
        issue0(1'b0, 8'd12, 8'd13, 1'b0, 1'b0);
        b0.aa = 8'd99; b0.bb = 8'd99; b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        wait0(3);
        chk("overrun_set", 64'(b0.overrun), 64'd1);
        chk("overrun_result", 64'(b0.out), 64'd156);

        // Reset two cycles into RUN aborts the operation.
        @(posedge clk); #1;
        issue0(1'b0, 8'd9, 8'd9, 1'b1, 1'b0);
        void'(sb0.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc0 = 32'd0; m_ovf0 = 1'b0;
        chk("abort_done", 64'(b0.done), 64'd0);
        chk("abort_ready", 64'(b0.ready), 64'd1);
        chk("abort_out", 64'(b0.out), 64'd0);
        chk("abort_acc", 64'(b0.acc), 64'd0);
        chk("abort_overrun", 64'(b0.overrun), 64'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (b0.done === 1'b1) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        issue0(1'b0, 8'd3, 8'd5, 1'b0, 1'b0);
        wait0(4);
        chk("after_abort_3x5", 64'(b0.out), 64'd15);

        // Reset and start together: start dropped.
        @(posedge clk); #1;
        b0.aa = 8'd7; b0.bb = 8'd7; b0.start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0; rst = 1'b0;
        chk("rst_start_ready", 64'(b0.ready), 64'd1);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (b0.done === 1'b1) seen++;
        end
        chk("rst_start_no_done", 64'(seen), 64'd0);
        chk("rst_start_out", 64'(b0.out), 64'd0);

        // Random sweep over sign / accumulate mixes.
        for (int i = 0; i < 200; i++) begin
            issue0(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            wait0(4);
        end

        // Narrow accumulator wrap and carry-out flag (II=2).
        run1(8'hFF, 8'hFF, 1'b1);
        chk("acc16_first", 64'(b1.acc), 64'hFE01);
        chk("acc16_noovf", 64'(b1.acc_ovf), 64'd0);
        run1(8'hFF, 8'hFF, 1'b0);
        chk("acc16_wrap", 64'(b1.acc), 64'hFC02);
        chk("acc16_ovf", 64'(b1.acc_ovf), 64'd1);

        // Wider configuration, 16x12 with three 4-bit chunks.
        run2(1'b1, 16'h8000, 12'h800, 1'b1, 1'b1);
        run2(1'b1, 16'h7FFF, 12'hFFF, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run2(1'($urandom_range(0, 1)), 16'($urandom), 12'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
